spi_slave_count_rx: RTL and testbench

SPI mode-0 slave receiver that is the far end of the counter-streaming SPI link. It oversamples the asynchronous SCLK/MOSI/n_SS lines in the system clock domain and shifts in two MSB-first bytes per n_SS frame (high byte, then low byte). It reassembles them into a 16-bit count and presents that count with a one-cycle valid strobe to the downstream display/FND logic. It sits on the receiving board, directly behind the SPI pins.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_slave_count_rx_if.sv | 12 +
 rtl/spi_slave_shifter.sv | 84 ++++++++
 rtl/spi_slave_count_rx.sv | 120 ++++++++++++
 tb/tb_spi_slave_count_rx.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and sizes for the counter-streaming SPI receive link.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        RX_HIGH      = 2'd1,
        RX_LOW       = 2'd2,
        WAIT_SS_HIGH = 2'd3
    } rx_state_t;

    localparam int BYTE_BITS   = 8;
    localparam int FRAME_BYTES = 2;
    localparam int COUNT_W     = BYTE_BITS * FRAME_BYTES;

endpackage

// File: rtl/spi_slave_count_rx_if.sv
// SPI pin bundle between the counter-streaming master and this receiver.
// Strobe semantics: SCLK is CPOL=0, MOSI launched on falling edges and captured on rising edges
// while n_SS is low; there is no ready/backpressure, the slave must keep up.
interface spi_slave_count_rx_if;
    logic SCLK;
    logic MOSI;
    logic n_SS;
    logic MISO;

    modport master (output SCLK, output MOSI, output n_SS, input MISO);
    modport slave  (input SCLK, input MOSI, input n_SS, output MISO);
endinterface

// File: rtl/spi_slave_shifter.sv
// Pin synchronizers, registered SCLK/n_SS edge strobes, and the 8-bit MSB-first shifter.
module spi_slave_shifter
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_sclk,
    input  logic                 i_mosi,
    input  logic                 i_n_ss,
    input  logic                 i_clear,
    input  logic                 i_enable,
    output logic                 o_ss_fall,
    output logic                 o_ss_rise,
    output logic [BYTE_BITS-1:0] o_rx_byte,
    output logic                 o_byte_done
);

    localparam int CNT_W = $clog2(BYTE_BITS);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic                   r_sclk_d;
    logic                   r_ss_d;
    logic                   r_sclk_rise;
    logic                   r_ss_fall;
    logic                   r_ss_rise;
    logic [BYTE_BITS-1:0]   r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;

    logic w_sclk_s;
    logic w_ss_s;
    logic w_mosi_s;
    logic w_sample;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s   = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ss_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
            r_sclk_rise <= 1'b0;
            r_ss_fall   <= 1'b0;
            r_ss_rise   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_n_ss};
            r_sclk_d    <= w_sclk_s;
            r_ss_d      <= w_ss_s;
            r_sclk_rise <= w_sclk_s & ~r_sclk_d;
            r_ss_fall   <= ~w_ss_s & r_ss_d;
            r_ss_rise   <= w_ss_s & ~r_ss_d;
        end
    end

    // r_ss_d is aligned with the registered strobes, so an SCLK edge landing with n_SS rise is dropped.
    assign w_sample    = i_enable & r_sclk_rise & ~r_ss_d;
    assign o_rx_byte   = {r_shift[BYTE_BITS-2:0], w_mosi_s};
    assign o_byte_done = w_sample & (r_bit_cnt == CNT_W'(BYTE_BITS - 1));
    assign o_ss_fall   = r_ss_fall;
    assign o_ss_rise   = r_ss_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (i_clear) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_sample) begin
            r_shift   <= o_rx_byte;
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_slave_count_rx.sv
// Frame FSM: assembles two received bytes into a 16-bit count with valid / abort strobes.
module spi_slave_count_rx
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_slave_count_rx_if.slave   spi,
    output logic [COUNT_W-1:0]    count_out,
    output logic                  count_valid,
    output logic                  frame_err,
    output logic                  busy,
    output rx_state_t             dbg_state
);

    rx_state_t             r_state;
    logic [BYTE_BITS-1:0]  r_high;
    logic [COUNT_W-1:0]    r_count;
    logic                  r_valid;
    logic                  r_err;

    rx_state_t             w_next_state;
    logic                  w_clear;
    logic                  w_enable;
    logic                  w_latch_high;
    logic                  w_complete;
    logic                  w_abort;
    logic                  w_ss_fall;
    logic                  w_ss_rise;
    logic [BYTE_BITS-1:0]  w_rx_byte;
    logic                  w_byte_done;

    spi_slave_shifter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .i_sclk      (spi.SCLK),
        .i_mosi      (spi.MOSI),
        .i_n_ss      (spi.n_SS),
        .i_clear     (w_clear),
        .i_enable    (w_enable),
        .o_ss_fall   (w_ss_fall),
        .o_ss_rise   (w_ss_rise),
        .o_rx_byte   (w_rx_byte),
        .o_byte_done (w_byte_done)
    );

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_enable     = 1'b0;
        w_latch_high = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall) begin
                    w_clear      = 1'b1;
                    w_next_state = RX_HIGH;
                end
            end
            RX_HIGH: begin
                w_enable = 1'b1;
                if (w_ss_rise) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end else if (w_byte_done) begin
                    w_latch_high = 1'b1;
                    w_next_state = RX_LOW;
                end
            end
            RX_LOW: begin
                w_enable = 1'b1;
                if (w_ss_rise) begin
                    w_abort      = 1'b1;
                    w_next_state = IDLE;
                end else if (w_byte_done) begin
                    w_complete   = 1'b1;
                    w_next_state = WAIT_SS_HIGH;
                end
            end
            WAIT_SS_HIGH: begin
                if (w_ss_rise) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_high  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_valid <= w_complete;
            r_err   <= w_abort;
            if (w_latch_high) begin
                r_high <= w_rx_byte;
            end
            if (w_complete) begin
                r_count <= {r_high, w_rx_byte};
            end
        end
    end

    assign spi.MISO    = 1'b0;
    assign count_out   = r_count;
    assign count_valid = r_valid;
    assign frame_err   = r_err;
    assign busy        = (r_state != IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_spi_slave_count_rx.sv
// Directed bench for spi_slave_count_rx: SCLK period 20 clk, MSB-first frames.
module tb_spi_slave_count_rx;
    import spi_pkg::*;

    logic         clk;
    logic         reset;
    logic [15:0]  count_out;
    logic         count_valid;
    logic         frame_err;
    logic         busy;
    rx_state_t    dbg_state;

    spi_slave_count_rx_if spi_if ();

    spi_slave_count_rx #(
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spi         (spi_if.slave),
        .count_out   (count_out),
        .count_valid (count_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int valid_cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [15:0] got_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (count_valid === 1'b1) begin
            n_valid   = n_valid + 1;
            valid_cyc = cyc;
            got_q.push_back(count_out);
        end
        if (frame_err === 1'b1) n_err = n_err + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        spi_if.MOSI = b;
        wait_clk(10);
        spi_if.SCLK = 1'b1;
        last_rise_cyc = cyc;
        wait_clk(10);
        spi_if.SCLK = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits);
        logic [31:0] sh;
        sh = w;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(sh[31]);
            sh = sh << 1;
        end
    endtask

    task automatic frame(input logic [31:0] w, input int nbits);
        spi_if.n_SS = 1'b0;
        wait_clk(10);
        send_bits(w, nbits);
        wait_clk(10);
        spi_if.n_SS = 1'b1;
        wait_clk(40);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        spi_if.SCLK = 1'b0;
        spi_if.MOSI = 1'b0;
        spi_if.n_SS = 1'b1;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(5);
        n_checks++;
        if (count_out !== 16'h0000) begin
            n_fails++; $display("FAIL reset_count got %h want 0000", count_out);
        end
        n_checks++;
        if ({count_valid, frame_err, busy, spi_if.MISO} !== 4'b0000) begin
            n_fails++; $display("FAIL reset_flags got %b want 0000", {count_valid, frame_err, busy, spi_if.MISO});
        end
        n_checks++;
        if (dbg_state !== IDLE) begin
            n_fails++; $display("FAIL reset_state got %0d want IDLE", dbg_state);
        end
    endtask

    task automatic test_single;
        int v0, e0, b0;
        v0 = n_valid; e0 = n_err; b0 = got_q.size();
        spi_if.n_SS = 1'b0;
        wait_clk(10);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fails++; $display("FAIL single_busy_high got %b want 1", busy);
        end
        send_bits({16'h1234, 16'h0}, 16);
        wait_clk(10);
        spi_if.n_SS = 1'b1;
        wait_clk(40);
        n_checks++;
        if (n_valid - v0 !== 1) begin
            n_fails++; $display("FAIL single_valid_pulses got %0d want 1", n_valid - v0);
        end else begin
            n_checks++;
            if (got_q[b0] !== 16'h1234) begin
                n_fails++; $display("FAIL single_value got %h want 1234", got_q[b0]);
            end
            n_checks++;
            if (valid_cyc - last_rise_cyc !== 4) begin
                n_fails++; $display("FAIL single_latency got %0d want 4", valid_cyc - last_rise_cyc);
            end
        end
        n_checks++;
        if (n_err - e0 !== 0) begin
            n_fails++; $display("FAIL single_no_err got %0d want 0", n_err - e0);
        end
        n_checks++;
        if (busy !== 1'b0 || count_out !== 16'h1234) begin
            n_fails++; $display("FAIL single_idle_after got busy=%b count=%h want busy=0 count=1234", busy, count_out);
        end
    endtask

    task automatic test_back_to_back;
        int v0, b0;
        v0 = n_valid; b0 = got_q.size();
        frame({16'h00FF, 16'h0}, 16);
        frame({16'hFF00, 16'h0}, 16);
        n_checks++;
        if (n_valid - v0 !== 2) begin
            n_fails++; $display("FAIL b2b_pulses got %0d want 2", n_valid - v0);
        end else begin
            n_checks++;
            if (got_q[b0] !== 16'h00FF) begin
                n_fails++; $display("FAIL b2b_first got %h want 00ff", got_q[b0]);
            end
            n_checks++;
            if (got_q[b0+1] !== 16'hFF00) begin
                n_fails++; $display("FAIL b2b_second got %h want ff00", got_q[b0+1]);
            end
        end
    endtask

    task automatic test_gap;
        int v0, b0;
        v0 = n_valid; b0 = got_q.size();
        spi_if.n_SS = 1'b0;
        wait_clk(10);
        send_bits({8'hFF, 24'h0}, 8);
        wait_clk(5000);
        n_checks++;
        if (busy !== 1'b1 || dbg_state !== RX_LOW || n_valid != v0) begin
            n_fails++; $display("FAIL gap_hold got busy=%b state=%0d pulses=%0d want busy=1 state=RX_LOW pulses=0", busy, dbg_state, n_valid - v0);
        end
        send_bits({8'hFF, 24'h0}, 8);
        wait_clk(10);
        spi_if.n_SS = 1'b1;
        wait_clk(40);
        frame({16'h0000, 16'h0}, 16);
        n_checks++;
        if (n_valid - v0 !== 2) begin
            n_fails++; $display("FAIL gap_pulses got %0d want 2", n_valid - v0);
        end else begin
            n_checks++;
            if (got_q[b0] !== 16'hFFFF || got_q[b0+1] !== 16'h0000) begin
                n_fails++; $display("FAIL gap_values got %h,%h want ffff,0000", got_q[b0], got_q[b0+1]);
            end
        end
    endtask

    task automatic test_abort;
        int v0, e0, b0;
        v0 = n_valid; e0 = n_err; b0 = got_q.size();
        frame({16'hABCD, 16'h0}, 12);
        n_checks++;
        if (n_err - e0 !== 1) begin
            n_fails++; $display("FAIL abort_err_pulses got %0d want 1", n_err - e0);
        end
        n_checks++;
        if (n_valid - v0 !== 0 || count_out !== 16'h0000) begin
            n_fails++; $display("FAIL abort_no_update got pulses=%0d count=%h want pulses=0 count=0000", n_valid - v0, count_out);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++; $display("FAIL abort_busy got %b want 0", busy);
        end
        frame({16'h5A5A, 16'h0}, 16);
        n_checks++;
        if (n_valid - v0 !== 1 || count_out !== 16'h5A5A) begin
            n_fails++; $display("FAIL abort_next_frame got pulses=%0d count=%h want pulses=1 count=5a5a", n_valid - v0, count_out);
        end
    endtask

    task automatic test_ignore;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        for (int i = 0; i < 20; i++) spi_bit(1'(i % 2));
        wait_clk(20);
        n_checks++;
        if (n_valid != v0 || n_err != e0 || dbg_state !== IDLE || count_out !== 16'h5A5A) begin
            n_fails++; $display("FAIL ignore_ss_high got pulses=%0d errs=%0d state=%0d count=%h want 0,0,IDLE,5a5a", n_valid - v0, n_err - e0, dbg_state, count_out);
        end
        frame({16'hC3A5, 2'b11, 14'h0}, 18);
        n_checks++;
        if (n_valid - v0 !== 1 || count_out !== 16'hC3A5) begin
            n_fails++; $display("FAIL ignore_extra_bits got pulses=%0d count=%h want pulses=1 count=c3a5", n_valid - v0, count_out);
        end
        n_checks++;
        if (n_err != e0) begin
            n_fails++; $display("FAIL ignore_no_err got %0d want 0", n_err - e0);
        end
    endtask

    task automatic test_reset_mid;
        int v0, e0;
        spi_if.n_SS = 1'b0;
        wait_clk(10);
        send_bits({16'h1357, 16'h0}, 10);
        reset = 1'b1;
        spi_if.n_SS = 1'b1;
        wait_clk(5);
        n_checks++;
        if (count_out !== 16'h0000 || {count_valid, frame_err, busy} !== 3'b000 || dbg_state !== IDLE) begin
            n_fails++; $display("FAIL midreset_values got count=%h flags=%b state=%0d want 0000 000 IDLE", count_out, {count_valid, frame_err, busy}, dbg_state);
        end
        reset = 1'b0;
        wait_clk(10);
        v0 = n_valid; e0 = n_err;
        frame({16'h2468, 16'h0}, 16);
        n_checks++;
        if (n_valid - v0 !== 1 || count_out !== 16'h2468 || n_err != e0) begin
            n_fails++; $display("FAIL midreset_next got pulses=%0d count=%h errs=%0d want 1 2468 0", n_valid - v0, count_out, n_err - e0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_abort();
        test_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
